// File: rtl/modsq_lut_phase_sched.sv
// modsq_lut_phase_sched
//   Sequencer for the modulus-reduction LUT bank of the modular squarer.
//   Each iteration accepts one address/bypass set, steps the bank through
//   clock phases 3, 2, 1, waits LUT_LATENCY cycles for the bank data to
//   settle, pulses lut_valid and counts the iteration down.
// Ports:
//   clk, reset      clock, async active-high reset
//   start/iters_in  run launch (IDLE only) and iteration count
//   abort           synchronous abort back to IDLE
//   addr_valid/ready, addrs_in, bypass_in   per-iteration address handshake
//   clk_phase, ce, bypass, lut_addrs        LUT bank drive
//   lut_valid, busy, done, iters_left       status

// Per-chunk bypass: requested bypass, or (ZERO_SKIP) the chunk's used
// address field [HI:LO] is all zero. The field is applied as a mask so the
// whole word stays in use.
module modsq_bypass_lane #(
  parameter int BIT_LEN   = 51,
  parameter int HI        = 50,
  parameter int LO        = 0,
  parameter int ZERO_SKIP = 1
) (
  input  logic [BIT_LEN-1:0] addr,
  input  logic               byp_req,
  output logic               byp
);
  localparam logic [BIT_LEN-1:0] MASK =
    ({BIT_LEN{1'b1}} >> (BIT_LEN - 1 - HI)) & ({BIT_LEN{1'b1}} << LO);

  assign byp = byp_req | ((ZERO_SKIP != 0) && ((addr & MASK) == '0));
endmodule

module modsq_lut_phase_sched #(
  parameter int BIT_LEN          = 51,
  parameter int ACC_NUM_ELEMENTS = 22,
  parameter int LUT_LATENCY      = 2,
  parameter int ZERO_SKIP        = 1,
  parameter int ITER_W           = 32
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic [ITER_W-1:0]                               iters_in,
  input  logic                                            abort,
  input  logic                                            addr_valid,
  output logic                                            addr_ready,
  input  logic [ACC_NUM_ELEMENTS-1:0][BIT_LEN-1:0]        addrs_in,
  input  logic [ACC_NUM_ELEMENTS-1:0]                     bypass_in,
  output logic [3:1]                                      clk_phase,
  output logic                                            ce,
  output logic [ACC_NUM_ELEMENTS-1:0]                     bypass,
  output logic [ACC_NUM_ELEMENTS-1:0][BIT_LEN-1:0]        lut_addrs,
  output logic                                            lut_valid,
  output logic                                            busy,
  output logic                                            done,
  output logic [ITER_W-1:0]                               iters_left
);

  typedef enum logic [2:0] {IDLE, ARM, P3, P2, P1, DRAIN} state_t;

  state_t                        state, state_nxt;
  logic [3:0]                    drain_cnt;
  logic                          done_q;
  logic [ACC_NUM_ELEMENTS-1:0]   byp_nxt;

  // Derived events
  logic start_go, start_zero, accept, drain_last, run_end;
  assign start_go   = (state == IDLE) && start && (iters_in != '0);
  assign start_zero = (state == IDLE) && start && (iters_in == '0);
  assign accept     = (state == ARM) && addr_valid;
  assign drain_last = (state == DRAIN) && (drain_cnt == '0);
  assign run_end    = drain_last && (iters_left == ITER_W'(1));

  // Per-chunk bypass lanes
  for (genvar i = 0; i < ACC_NUM_ELEMENTS; i++) begin : g_lane
    localparam int HI = (i == ACC_NUM_ELEMENTS - 1) ? 14 : BIT_LEN - 1;
    localparam int LO = (i == 0) ? 21 : 0;
    modsq_bypass_lane #(
      .BIT_LEN(BIT_LEN), .HI(HI), .LO(LO), .ZERO_SKIP(ZERO_SKIP)
    ) u_lane (
      .addr    (addrs_in[i]),
      .byp_req (bypass_in[i]),
      .byp     (byp_nxt[i])
    );
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = ARM;
      ARM:     if (addr_valid) state_nxt = P3;
      P3:      state_nxt = P2;
      P2:      state_nxt = P1;
      P1:      state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = run_end ? IDLE : ARM;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Datapath / counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt  <= '0;
      done_q     <= 1'b0;
      iters_left <= '0;
      lut_addrs  <= '0;
      bypass     <= '0;
    end else begin
      done_q <= !abort && (start_zero || run_end);

      if (state == P1)                 drain_cnt <= 4'(LUT_LATENCY - 1);
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 4'd1;

      if (abort)           iters_left <= '0;
      else if (start_go)   iters_left <= iters_in;
      else if (drain_last) iters_left <= iters_left - ITER_W'(1);

      // Abort leaves the latched bank inputs untouched.
      if (accept && !abort) begin
        lut_addrs <= addrs_in;
        bypass    <= byp_nxt;
      end
    end
  end

  // Output decodes of registered state
  assign addr_ready = (state == ARM);
  assign clk_phase  = {state == P3, state == P2, state == P1};
  assign ce         = (state == P3) || (state == P2) || (state == P1);
  assign lut_valid  = drain_last;
  assign busy       = (state != IDLE);
  assign done       = done_q;

endmodule
